mux_n_to_1_reg: RTL and testbench

Parametrised, registered N:1 datapath multiplexer with valid/ready handshake on every input and on the output. It generalises the fixed 16-input, 32-bit combinational selector used in the 32-bit processor datapath to arbitrary width and input count. It adds a round-robin arbitration mode beside the directed-select mode. It sits between multiple producers (register-file read ports, ALU/memory result paths) and a single consumer stage, and provides one pipeline register of buffering.

---
 rtl/mux_n_to_1_reg_if.sv | 27 ++
 rtl/mux_n_to_1_reg.sv | 117 +++++++++++
 tb/tb_mux_n_to_1_reg.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_to_1_reg_if.sv
// Handshake bundle for mux_n_to_1_reg: N producer channels in, one consumer out.
// master = producer/consumer side, slave = the mux itself.
interface mux_n_to_1_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_n_to_1_reg.sv
// Registered N:1 mux with valid/ready on every channel; directed-select or
// round-robin arbitration feeding a single output pipeline register.
module mux_n_to_1_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  mux_n_to_1_reg_if.slave     bus
);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic                load_en;
  logic                grant;
  logic                xfer;
  logic [SEL_W-1:0]    gnt_idx;
  logic [WIDTH-1:0]    gnt_data;
  logic [NUM_IN-1:0]   in_ready;
  logic [2*NUM_IN-1:0] vld_dbl;
  logic [NUM_IN-1:0]   vld_rot;
  logic [SEL_W:0]      rr_shift;
  logic [SEL_W:0]      ch_sum;

  assign load_en = !out_valid_q || bus.out_ready;

  // Round-robin: rotate the doubled valid vector so bit 0 is channel rr_ptr+1;
  // the lowest set bit is then the winner.
  always_comb begin
    grant    = 1'b0;
    gnt_idx  = '0;
    ch_sum   = '0;
    rr_shift = {1'b0, rr_ptr_q} + (SEL_W+1)'(1);
    vld_dbl  = {bus.in_valid, bus.in_valid};
    vld_rot  = NUM_IN'(vld_dbl >> rr_shift);
    if (!bus.mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant   = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int j = NUM_IN - 1; j >= 0; j--) begin
        if (vld_rot[j]) begin
          grant  = 1'b1;
          ch_sum = rr_shift + (SEL_W+1)'(j);
          if (ch_sum >= (SEL_W+1)'(NUM_IN)) begin
            ch_sum = ch_sum - (SEL_W+1)'(NUM_IN);
          end
          gnt_idx = ch_sum[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset blocks the transfer so a word presented during reset is never taken.
  assign xfer = load_en && grant && !reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer) begin
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (bus.mode) begin
        rr_ptr_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Scoreboard bench for mux_n_to_1_reg: a 16-input instance for select, backpressure
// and round-robin behaviour, and a 10-input instance for out-of-range select and wrap.
module tb_mux_n_to_1_reg;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  mux_n_to_1_reg_if #(.WIDTH(W), .NUM_IN(16), .SEL_W(4)) ifa ();
  mux_n_to_1_reg_if #(.WIDTH(W), .NUM_IN(10), .SEL_W(4)) ifb ();

  mux_n_to_1_reg #(.WIDTH(W), .NUM_IN(16), .SEL_W(4)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa.slave)
  );

  mux_n_to_1_reg #(.WIDTH(W), .NUM_IN(10), .SEL_W(4)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb.slave)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  sel;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input int ch);
    exp_t e;
    e.data = 32'hA000_0000 + 32'(ch);
    e.sel  = 4'(ch);
    qa.push_back(e);
  endtask

  task automatic push_b(input int ch);
    exp_t e;
    e.data = 32'hB000_0000 + 32'(ch);
    e.sel  = 4'(ch);
    qb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a         = 1'b1;
    ifa.in_valid  = '1;
    ifa.mode      = 1'b1;
    ifa.out_ready = 1'b1;
    repeat (3) begin
      cyc();
      check("a_rst_in_ready", 64'(ifa.in_ready), 64'd0);
      check("a_rst_out_valid", 64'(ifa.out_valid), 64'd0);
      check("a_rst_out_data", 64'(ifa.out_data), 64'd0);
    end
    rst_a = 1'b0;
  endtask

  // Monitors: a word is consumed at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_word: got data %0h sel %0d, required no word", ifa.out_data, ifa.out_sel);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_out_data", 64'(ifa.out_data), 64'(e.data));
        check("a_out_sel", 64'(ifa.out_sel), 64'(e.sel));
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_word: got data %0h sel %0d, required no word", ifb.out_data, ifb.out_sel);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_out_data", 64'(ifb.out_data), 64'(e.data));
        check("b_out_sel", 64'(ifb.out_sel), 64'(e.sel));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run, required finish within 200000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 16; i++) ifa.in_data[i*W +: W] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 10; i++) ifb.in_data[i*W +: W] = 32'hB000_0000 + 32'(i);
    ifa.in_valid  = '1;
    ifa.mode      = 1'b1;
    ifa.sel       = '0;
    ifa.out_ready = 1'b1;
    ifb.in_valid  = '1;
    ifb.mode      = 1'b1;
    ifb.sel       = '0;
    ifb.out_ready = 1'b1;

    // Reset, then first round-robin grant goes to channel 0.
    reset_a();
    push_a(0);
    cyc();
    ifa.in_valid = '0;
    cyc();

    // Directed select, back-to-back 5 then 15.
    ifa.mode     = 1'b0;
    ifa.sel      = 4'd5;
    ifa.in_valid = 16'h0020;
    push_a(5);
    cyc();
    ifa.sel      = 4'd15;
    ifa.in_valid = 16'h8000;
    push_a(15);
    cyc();
    ifa.in_valid = '0;
    cyc();
    cyc();

    // Backpressure: hold word 9 for 10 cycles, then drain it while loading channel 3.
    ifa.out_ready = 1'b0;
    ifa.sel       = 4'd9;
    ifa.in_valid  = 16'h0200;
    push_a(9);
    cyc();
    ifa.sel      = 4'd3;
    ifa.in_valid = 16'h0008;
    repeat (10) begin
      check("a_bp_in_ready", 64'(ifa.in_ready), 64'd0);
      check("a_bp_out_data", 64'(ifa.out_data), 64'hA000_0009);
      check("a_bp_out_valid", 64'(ifa.out_valid), 64'd1);
      cyc();
    end
    ifa.out_ready = 1'b1;
    push_a(3);
    cyc();
    ifa.in_valid = '0;
    cyc();
    cyc();

    // Round-robin fairness over 32 grants, then only channels 0..3 valid.
    reset_a();
    for (int i = 0; i < 32; i++) begin
      push_a(i % 16);
      cyc();
    end
    ifa.in_valid = 16'h000F;
    for (int k = 0; k < 5; k++) begin
      push_a(k % 4);
      cyc();
    end
    ifa.in_valid = '0;
    cyc();
    cyc();

    // Mode switch keeps rr_ptr: RR 0,1,2, directed 7,7, RR resumes at 3.
    reset_a();
    for (int i = 0; i < 3; i++) begin
      push_a(i);
      cyc();
    end
    ifa.mode = 1'b0;
    ifa.sel  = 4'd7;
    push_a(7);
    cyc();
    push_a(7);
    cyc();
    ifa.mode = 1'b1;
    push_a(3);
    cyc();
    ifa.in_valid = '0;
    cyc();
    cyc();

    // 10-input instance: reset, round-robin wrap 0..9,0.
    check("b_rst_in_ready", 64'(ifb.in_ready), 64'd0);
    check("b_rst_out_valid", 64'(ifb.out_valid), 64'd0);
    rst_b = 1'b0;
    for (int i = 0; i < 11; i++) begin
      push_b(i % 10);
      cyc();
    end
    ifb.in_valid = '0;
    cyc();

    // Out-of-range select: held word drains, nothing new granted.
    ifb.in_valid  = '1;
    ifb.out_ready = 1'b0;
    ifb.mode      = 1'b0;
    ifb.sel       = 4'd2;
    push_b(2);
    cyc();
    ifb.sel       = 4'd12;
    ifb.out_ready = 1'b1;
    check("b_oor_in_ready", 64'(ifb.in_ready), 64'd0);
    cyc();
    check("b_oor_in_ready_after", 64'(ifb.in_ready), 64'd0);
    check("b_oor_out_valid", 64'(ifb.out_valid), 64'd0);
    cyc();
    check("b_oor_out_valid_hold", 64'(ifb.out_valid), 64'd0);
    ifb.in_valid = '0;

    repeat (3) cyc();
    check("a_queue_empty", 64'(qa.size()), 64'd0);
    check("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
